// File: rtl/matrix_pkg.sv
// Shared types and default sizing for the matrix-multiply loader path.
package matrix_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_MATRIX_DIM = 8;
    localparam int unsigned MATRIX_ELEMS   = DEF_MATRIX_DIM * DEF_MATRIX_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_Y,
        ST_KICK,
        ST_WAIT,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Row/column walker over an N x N matrix; emits row-major and transposed addresses.
module matrix_addr_gen
    import matrix_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MATRIX_DIM = DEF_MATRIX_DIM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  last,
    output logic [ADDR_WIDTH-1:0] addr_rm,
    output logic [ADDR_WIDTH-1:0] addr_tr
);

    localparam logic [ADDR_WIDTH-1:0] DIM      = ADDR_WIDTH'(MATRIX_DIM);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MATRIX_DIM - 1);

    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;

    assign last    = (row == LAST_IDX) && (col == LAST_IDX);
    assign addr_rm = row * DIM + col;
    assign addr_tr = col * DIM + row;

    // Wrapping off the final element returns to (0,0) for the next matrix.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear || (advance && last)) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= row + ADDR_WIDTH'(1);
            end else begin
                col <= col + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Drains X then Y from a FWFT FIFO into operand BRAMs, kicks the multiplier, awaits completion.
// Build option: MATRIX_LOADER_TRANSPOSE_Y_EN stores Y transposed (col*N + row).
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MATRIX_DIM = DEF_MATRIX_DIM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  y_wr_en,
    output logic                  mult_start,
    input  logic                  mult_done
);

`ifdef MATRIX_LOADER_TRANSPOSE_Y_EN
    localparam bit TRANSPOSE_Y = 1'b1;
`else
    localparam bit TRANSPOSE_Y = 1'b0;
`endif

    loader_state_t         state;
    logic                  seen_low;
    logic                  loading_x;
    logic                  loading_y;
    logic                  pop;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr_rm;
    logic [ADDR_WIDTH-1:0] addr_tr;

    assign loading_x = (state == ST_LOAD_X);
    assign loading_y = (state == ST_LOAD_Y);
    assign pop       = (loading_x || loading_y) && !in_empty;

    assign in_rd_en = pop;
    assign x_wr_en  = loading_x && !in_empty;
    assign y_wr_en  = loading_y && !in_empty;
    assign x_din    = loading_x ? in_dout : '0;
    assign y_din    = loading_y ? in_dout : '0;
    assign x_addr   = addr_rm;
    assign y_addr   = TRANSPOSE_Y ? addr_tr : addr_rm;

    matrix_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATRIX_DIM (MATRIX_DIM)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .advance (pop),
        .last    (last),
        .addr_rm (addr_rm),
        .addr_tr (addr_tr)
    );

    // mult_done is a level left over from the previous run, so require a low before accepting a high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            mult_start <= 1'b0;
            seen_low   <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD_X;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_X: begin
                    if (pop && last) state <= ST_LOAD_Y;
                end
                ST_LOAD_Y: begin
                    if (pop && last) begin
                        state      <= ST_KICK;
                        mult_start <= 1'b1;
                    end
                end
                ST_KICK: begin
                    seen_low <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mult_done) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: FIFO model, write scoreboard, vector table plus reset/handshake sequences.
module tb_matrix_loader;

    localparam int unsigned N  = 8;
    localparam int unsigned NE = N * N;

    typedef struct {
        bit stall;
        bit pulse;
        int x_base;
        int y_base;
        int exp_kick;
    } vec_t;

    typedef struct {
        bit          is_y;
        logic [9:0]  addr;
        logic [31:0] data;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        busy;
    logic [31:0] in_dout = '0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [31:0] x_din;
    logic [9:0]  x_addr;
    logic        x_wr_en;
    logic [31:0] y_din;
    logic [9:0]  y_addr;
    logic        y_wr_en;
    logic        mult_start;
    logic        mult_done = 1'b0;

    matrix_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .in_dout    (in_dout),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .x_din      (x_din),
        .x_addr     (x_addr),
        .x_wr_en    (x_wr_en),
        .y_din      (y_din),
        .y_addr     (y_addr),
        .y_wr_en    (y_wr_en),
        .mult_start (mult_start),
        .mult_done  (mult_done)
    );

    always #5 clock = ~clock;

    logic [31:0] fifo_q[$];
    sb_t         sb_q[$];
    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          kick_count = 0;
    int          kick_cyc = 0;
    int          xw_cnt = 0;
    bit          y_seen = 0;
    bit          stall_en = 0;
    bit          stall_phase = 0;
    bit          pop_req = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic upd();
        in_empty = (fifo_q.size() == 0) || (stall_en && stall_phase);
        in_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
    endtask

    // One clock: check outputs at the falling edge, then advance the FIFO model after the rising edge.
    task automatic tick();
        sb_t         e;
        logic [42:0] act;
        @(negedge clock);
        if (busy && in_empty) chk("pop_while_empty", 64'(in_rd_en), 64'(0));
        if (in_rd_en || x_wr_en || y_wr_en) begin
            chk("rd_wr_match", 64'(in_rd_en), 64'(x_wr_en | y_wr_en));
            chk("port_excl", 64'(x_wr_en & y_wr_en), 64'(0));
        end
        if (x_wr_en || y_wr_en) begin
            if (y_wr_en) y_seen = 1;
            if (x_wr_en) xw_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'(sb_q.size()), 64'(1));
            end else begin
                e   = sb_q.pop_front();
                act = x_wr_en ? {1'b0, x_addr, x_din} : {1'b1, y_addr, y_din};
                chk(x_wr_en ? "x_write" : "y_write", 64'(act), 64'({e.is_y, e.addr, e.data}));
            end
        end
        if (mult_start) begin
            kick_count++;
            kick_cyc = cyc;
        end
        pop_req = in_rd_en;
        @(posedge clock);
        cyc++;
        #1;
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (stall_en) stall_phase = ~stall_phase;
        upd();
    endtask

    task automatic preload(input vec_t v);
        sb_t e;
        for (int a = 0; a < int'(NE); a++) begin
            fifo_q.push_back(32'(v.x_base + a));
            e.is_y = 0; e.addr = 10'(a); e.data = 32'(v.x_base + a);
            sb_q.push_back(e);
        end
        for (int a = 0; a < int'(NE); a++) begin
            fifo_q.push_back(32'(v.y_base + a));
            e.is_y = 1;
`ifdef MATRIX_LOADER_TRANSPOSE_Y_EN
            e.addr = 10'((a % int'(N)) * int'(N) + a / int'(N));
`else
            e.addr = 10'(a);
`endif
            e.data = 32'(v.y_base + a);
            sb_q.push_back(e);
        end
        upd();
    endtask

    task automatic run_vec(input vec_t v);
        int kc0;
        int start_cyc;
        int rel;
        int n;
        bit pulsed;
        preload(v);
        kc0 = kick_count;
        y_seen = 0;
        pulsed = 0;
        stall_en = v.stall;
        stall_phase = 0;
        start = 1;
        tick();
        start = 0;
        start_cyc = cyc;
        chk("start_accept", 64'({done, busy}), 64'(2'b01));
        n = 0;
        while (kick_count == kc0 && n < 600) begin
            start = v.pulse && !pulsed && y_seen;
            if (start) pulsed = 1;
            tick();
            n++;
        end
        start = 0;
        rel = (kick_count != kc0) ? (kick_cyc - start_cyc + 1) : 0;
        chk("kick_cycle", 64'(rel), 64'(v.exp_kick));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        stall_en = 0;
        upd();
        for (int i = 0; i < 3; i++) begin
            start = v.pulse && (i == 1);
            tick();
            chk("no_early_done", 64'({done, busy}), 64'(2'b01));
        end
        start = 0;
        mult_done = 0;
        tick();
        tick();
        chk("wait_low", 64'({done, busy}), 64'(2'b01));
        mult_done = 1;
        tick();
        chk("done_rise", 64'(done), 64'(1));
        tick();
        chk("back_idle", 64'({done, busy}), 64'(2'b10));
        repeat (3) tick();
        chk("done_hold", 64'({done, busy}), 64'(2'b10));
        chk("single_kick", 64'(kick_count - kc0), 64'(1));
    endtask

    initial begin
        int n;
        vecs[0] = '{stall: 0, pulse: 0, x_base: 0,   y_base: 100,    exp_kick: 129};
        vecs[1] = '{stall: 1, pulse: 0, x_base: 0,   y_base: 100,    exp_kick: 257};
        vecs[2] = '{stall: 0, pulse: 1, x_base: -50, y_base: 100000, exp_kick: 129};
        vecs[3] = '{stall: 1, pulse: 1, x_base: 7,   y_base: -3,     exp_kick: 257};

        repeat (2) tick();
        chk("reset_ctrl", 64'({done, busy, in_rd_en, x_wr_en, y_wr_en, mult_start, x_addr, y_addr}), 64'(0));
        chk("reset_data", 64'({x_din, y_din}), 64'(0));
        reset = 0;
        tick();
        chk("idle_ctrl", 64'({done, busy, in_rd_en, x_wr_en, y_wr_en, mult_start}), 64'(0));

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset asserted after 30 X writes, then a fresh batch must start at address 0.
        preload(vecs[0]);
        xw_cnt = 0;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (xw_cnt < 30 && n < 200) begin
            tick();
            n++;
        end
        chk("mid_writes", 64'(xw_cnt), 64'(30));
        reset = 1;
        #1;
        chk("async_reset_ctrl", 64'({done, busy, in_rd_en, x_wr_en, y_wr_en, mult_start, x_addr, y_addr}), 64'(0));
        chk("async_reset_data", 64'({x_din, y_din}), 64'(0));
        fifo_q.delete();
        sb_q.delete();
        upd();
        tick();
        tick();
        reset = 0;
        tick();
        chk("post_reset_idle", 64'({done, busy, x_addr}), 64'(0));
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream stage of the 8×8 matrix-multiply datapath. Drains a first-word-fall-through input FIFO carrying two matrices in row-major order, X first and then Y, and writes them into the X and Y operand BRAMs. It then pulses `mult_start` to the multiplier, waits for `mult_done`, and reports completion. It runs one batch per `start` and owns the operand memories' write ports while busy.

## Interface
- `DATA_WIDTH`, 32: element width; signed two's complement, passed through unmodified.
- `ADDR_WIDTH`, 10: BRAM address width.
- `MATRIX_DIM`, 8: matrix side length N; N*N elements per matrix; N*N must be ≤ 2^ADDR_WIDTH.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin one batch; sampled only in IDLE.
- `done`  out  1  batch complete; held high until the next accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_dout`  in  DATA_WIDTH  FIFO head data, valid whenever `in_empty`=0.
- `in_empty`  in  1  FIFO empty.
- `in_rd_en`  out  1  pop FIFO head this cycle.
- `x_din`  out  DATA_WIDTH  X BRAM write data.
- `x_addr`  out  ADDR_WIDTH  X BRAM write address.
- `x_wr_en`  out  1  X BRAM write enable.
- `y_din`  out  DATA_WIDTH  Y BRAM write data.
- `y_addr`  out  ADDR_WIDTH  Y BRAM write address.
- `y_wr_en`  out  1  Y BRAM write enable.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_done`  in  1  multiplier completion.

## Operation
- **States:** IDLE, LOAD_X, LOAD_Y, KICK, WAIT, DONE.
- **IDLE**
  - Row and column counters are held at 0.
  - `start`=1 moves to LOAD_X and clears `done` on the next edge.
- **LOAD_X**
  - `in_rd_en` = !`in_empty`; `x_wr_en` = `in_rd_en`.
  - `x_din` = `in_dout`; `x_addr` = row*N + col.
  - Each pop advances col; on col = N-1 col wraps to 0 and row increments.
  - The pop of element (N-1, N-1) clears the counters and moves to LOAD_Y.
- **LOAD_Y**
  - Identical to LOAD_X, targeting the Y port.
  - The last pop moves to KICK.
- **KICK**
  - `mult_start`=1 for exactly this one cycle.
  - Always moves to WAIT.
- **WAIT**
  - Holds until `mult_done`=1, then moves to DONE.
  - The multiplier's `done` is a level, so the loader first waits for `mult_done` to fall, then for it to rise.
  - Implement this with a registered "seen low" flag that clears on KICK.
- **DONE**
  - Sets `done`=1; moves to IDLE on the next cycle.
- **Write-port exclusivity:** the write enables are 0 outside their own load state. X and Y enables are never high in the same cycle.
- **Address width:** address arithmetic is unsigned and computed at ADDR_WIDTH; the counters are ADDR_WIDTH wide.
- **Boundary conditions**
  - An empty FIFO stalls the load with no pop, no write and the counter held.
  - `start` outside IDLE is ignored.
  - `mult_done` outside WAIT is ignored.
  - Reset mid-load returns all registers to reset values; partial BRAM contents are undefined.

## Timing
- **Reset values:**
  - All outputs 0: `done`, `busy`, `in_rd_en`, the write enables, all addresses and data, and `mult_start`.
  - State is IDLE.
- **Combinational outputs:** `in_rd_en`, the write enables, `x_din`/`y_din` and the addresses are combinational from state, counters and `in_empty`.
- **Throughput:** one element per cycle when the FIFO is never empty.
- **Minimum latency:** `start` accepted at edge 0 → LOAD_X for 64 cycles → LOAD_Y for 64 cycles → KICK at cycle 129 → WAIT.
- **Done timing:** `done` rises on the edge after the cycle in which WAIT samples the rising `mult_done`.
- **Registered outputs:** `done`, `busy` and `mult_start` are registered.

## Configuration
- **`MATRIX_LOADER_TRANSPOSE_Y_EN`**
  - Defined: `y_addr` = col*N + row, so Y is stored transposed and the multiplier can stream its columns contiguously.
  - Undefined: `y_addr` = row*N + col, the same as X.
  - X addressing is unaffected either way.

## Structure
- **Package `matrix_pkg`**
  - `loader_state_t` enum.
  - Default `DATA_WIDTH`, `ADDR_WIDTH` and `MATRIX_DIM` constants.
  - A `MATRIX_ELEMS` = MATRIX_DIM*MATRIX_DIM localparam.
- **Sub-module `matrix_addr_gen`**
  - Row/column counter with `clear`, `advance` and a `last` flag.
  - Produces the row-major and transposed addresses.
  - One instance is reused across X and Y.

## Test plan
- **Full-rate load:** FIFO preloaded with X = 0..63 and Y = 100..163 →
  - `x_wr_en` is high for 64 consecutive cycles writing X[a]=a.
  - `y_wr_en` is high for the next 64, writing Y[a]=100+a.
  - `mult_start` pulses once at cycle 129.
- **Stalls:** `in_empty` toggled every other cycle during the loads →
  - No writes or pops while empty.
  - Final contents are identical to the full-rate case.
  - The load takes 256 cycles.
- **Transpose:** with `MATRIX_LOADER_TRANSPOSE_Y_EN` defined, element 100+r*8+c is written to Y address c*8+r (e.g. value 111 lands at address 25).
- **Handshake:**
  - `mult_done` held high from the previous run → no completion until it falls and rises again.
  - `done` then rises one cycle after the rise and stays high until the next `start`.
- **Ignored inputs:** `start` pulsed during LOAD_Y and during WAIT → no restart, and counters are undisturbed.
- **Reset mid-operation:** `reset` asserted after 30 X writes → all outputs 0 immediately (asynchronous), state IDLE; a subsequent `start` loads from address 0.
